fractal_iter_pipe: RTL and testbench



---
 rtl/fractal_iter_pipe.sv | 275 +++++++++++++++++++++++++++
 tb/tb_fractal_iter_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_iter_pipe.sv
// fractal_iter_pipe: pipelined fractal iteration step placed in the FIFO
// recirculation loop. Each pending pixel word {PxVal, X, Y, Iteration}
// popped from the read FIFO is advanced by one z = z^2 + c step and pushed
// to the write FIFO STAGES cycles later. The whole pipe freezes while the
// write FIFO is full and the last stage holds a valid word.
//
// Optional build macro FRACTAL_SATURATE_EN: clamp X'/Y' to the W-bit signed
// range instead of wrapping modulo 2^W.
//
// Draw codes: 0 clear, 1 Mandelbrot, 2 Julia, 3 pass-through.

module fractal_iter_pipe #(
  parameter int W        = 32,
  parameter int FRAC     = 27,
  parameter int ITW      = 32,
  parameter int PXW      = 8,
  parameter int STAGES   = 3,
  parameter int H_RES    = 800,
  parameter int V_RES    = 480,
  parameter int MAX_ITER = 127
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [PXW+2*W+ITW-1:0] i_Px_Data,
  input  logic                   i_Read_Fifo_Empty,
  input  logic                   i_Write_Fifo_Full,
  input  logic [1:0]             i_Draw,
  input  logic [W-1:0]           i_X_Start,
  input  logic [W-1:0]           i_Y_Start,
  input  logic [W-1:0]           i_X_Inc,
  input  logic [W-1:0]           i_Y_Inc,
  input  logic [W-1:0]           i_Cx,
  input  logic [W-1:0]           i_Cy,
  output logic [PXW+2*W+ITW-1:0] o_Px_Data,
  output logic                   o_Read_Fifo_Ack,
  output logic                   o_Write_Fifo_Wrreq,
  output logic                   o_Frame_Done
);

  localparam int DW = PXW + 2*W + ITW;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [1:0] DRAW_CLEAR      = 2'd0;
  localparam logic [1:0] DRAW_MANDELBROT = 2'd1;
  localparam logic [1:0] DRAW_JULIA      = 2'd2;

  // 4.0 in Q(W-FRAC).FRAC, one bit wider so the magnitude sum cannot wrap.
  localparam logic [W:0] C_FOUR = (W+1)'(1) << (FRAC + 2);

  // One pipeline stage: the word itself, the draw mode it was accepted
  // under, the multiplier operands, the additive constants, and (from stage
  // STAGES-1 onward) the scaled products.
  typedef struct packed {
    logic [PXW-1:0] pxv;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [ITW-1:0] iter;
    logic [1:0]     mode;
    logic [W-1:0]   opx;
    logic [W-1:0]   opy;
    logic [W-1:0]   addx;
    logic [W-1:0]   addy;
    logic [W-1:0]   x2;
    logic [W-1:0]   y2;
    logic [W-1:0]   xy;
  } stage_t;

  // Signed fixed-point multiply, keeping the W bits aligned to FRAC.
  function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    return p[W+FRAC-1:FRAC];
  endfunction

  logic [W-1:0]      r_x_start, r_y_start, r_x_inc, r_y_inc, r_cx, r_cy;
  logic [XW-1:0]     r_px_x;
  logic [YW-1:0]     r_px_y;
  stage_t            r_pipe [1:STAGES-1];
  logic [STAGES-1:1] r_valid;
  logic              r_v_last;

  logic              w_adv, w_ack, w_last_x, w_last_y, w_frame_wrap;
  logic [W-1:0]      w_x0, w_y0;
  logic [PXW-1:0]    w_in_pxv;
  logic [W-1:0]      w_in_x, w_in_y;
  logic [ITW-1:0]    w_in_iter;
  stage_t            w_stage1, w_prod_src, w_tail;
  stage_t            w_next [1:STAGES-1];
  logic [W:0]        w_mag;
  logic              w_gt4, w_esc_in;
  logic [ITW-1:0]    w_iter_inc;
  logic [W-1:0]      w_new_x, w_new_y;
  logic [PXW-1:0]    w_res_pxv;
  logic [W-1:0]      w_res_x, w_res_y;
  logic [ITW-1:0]    w_res_iter;

  assign w_adv              = ~(r_v_last & i_Write_Fifo_Full);
  assign w_ack              = ~i_Read_Fifo_Empty & w_adv & ~i_Reset;
  assign o_Read_Fifo_Ack    = w_ack;
  assign o_Write_Fifo_Wrreq = r_v_last & ~i_Write_Fifo_Full & ~i_Reset;

  assign w_last_x     = (r_px_x == XW'(H_RES - 1));
  assign w_last_y     = (r_px_y == YW'(V_RES - 1));
  assign w_frame_wrap = w_ack & w_last_x & w_last_y;

  // Pixel position of the word being accepted, viewport reload at frame wrap.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_px_x       <= '0;
      r_px_y       <= '0;
      o_Frame_Done <= 1'b0;
      r_x_start    <= i_X_Start;
      r_y_start    <= i_Y_Start;
      r_x_inc      <= i_X_Inc;
      r_y_inc      <= i_Y_Inc;
      r_cx         <= i_Cx;
      r_cy         <= i_Cy;
    end else begin
      o_Frame_Done <= w_frame_wrap;
      if (w_ack) begin
        if (w_last_x) begin
          r_px_x <= '0;
          r_px_y <= w_last_y ? '0 : r_px_y + YW'(1);
        end else begin
          r_px_x <= r_px_x + XW'(1);
        end
      end
      if (w_frame_wrap) begin
        r_x_start <= i_X_Start;
        r_y_start <= i_Y_Start;
        r_x_inc   <= i_X_Inc;
        r_y_inc   <= i_Y_Inc;
        r_cx      <= i_Cx;
        r_cy      <= i_Cy;
      end
    end
  end

  assign w_x0 = r_x_start + r_x_inc * W'(r_px_x);
  assign w_y0 = r_y_start + r_y_inc * W'(r_px_y);

  assign w_in_pxv  = i_Px_Data[DW-1 -: PXW];
  assign w_in_x    = i_Px_Data[2*W+ITW-1 -: W];
  assign w_in_y    = i_Px_Data[W+ITW-1 -: W];
  assign w_in_iter = i_Px_Data[ITW-1:0];

  // Stage-1 operands: a zero coordinate means "first visit", seed from the viewport.
  always_comb begin
    w_stage1      = '0;
    w_stage1.pxv  = w_in_pxv;
    w_stage1.x    = w_in_x;
    w_stage1.y    = w_in_y;
    w_stage1.iter = w_in_iter;
    w_stage1.mode = i_Draw;
    w_stage1.opx  = (w_in_x == '0) ? w_x0 : w_in_x;
    w_stage1.opy  = (w_in_y == '0) ? w_y0 : w_in_y;
    w_stage1.addx = w_x0 | r_cx;
    w_stage1.addy = w_y0 | r_cy;
  end

  // Products are formed from the stage feeding STAGES-1; with a 2-deep pipe
  // that is the stage-1 input itself.
  generate
    if (STAGES == 2) begin : g_prod_src_in
      assign w_prod_src = w_stage1;
    end else begin : g_prod_src_pipe
      assign w_prod_src = r_pipe[STAGES-2];
    end
  endgenerate

  // Next contents of every stage; products land in stage STAGES-1.
  always_comb begin
    w_next[1] = w_stage1;
    for (int k = 2; k <= STAGES - 1; k++) begin
      w_next[k] = r_pipe[k-1];
    end
    w_next[STAGES-1].x2 = fx_mul(w_prod_src.opx, w_prod_src.opx);
    w_next[STAGES-1].y2 = fx_mul(w_prod_src.opy, w_prod_src.opy);
    w_next[STAGES-1].xy = fx_mul(w_prod_src.opx, w_prod_src.opy);
  end

  // Pipeline registers: all stages move together or hold together.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_valid <= '0;
    end else if (w_adv) begin
      for (int k = 1; k <= STAGES - 1; k++) begin
        r_pipe[k] <= w_next[k];
      end
      r_valid[1] <= w_ack;
      for (int k = 2; k <= STAGES - 1; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  assign w_tail     = r_pipe[STAGES-1];
  assign w_mag      = {w_tail.x2[W-1], w_tail.x2} + {w_tail.y2[W-1], w_tail.y2};
  assign w_gt4      = $signed(w_mag) > $signed(C_FOUR);
  assign w_esc_in   = (w_tail.x == '1) && (w_tail.y == '1);
  assign w_iter_inc = w_tail.iter + ITW'(1);

`ifdef FRACTAL_SATURATE_EN
  function automatic logic [W+1:0] sx2(input logic [W-1:0] a);
    return {{2{a[W-1]}}, a};
  endfunction

  // Clamped values are never all-ones or zero, so they cannot look like sentinels.
  function automatic logic [W-1:0] sat(input logic [W+1:0] s);
    if ($signed(s) > $signed({3'b000, {(W-1){1'b1}}}))
      return {1'b0, {(W-1){1'b1}}};
    else if ($signed(s) < $signed({3'b111, {(W-1){1'b0}}}))
      return {1'b1, {(W-1){1'b0}}};
    else
      return s[W-1:0];
  endfunction

  assign w_new_x = sat(sx2(w_tail.x2) - sx2(w_tail.y2) + sx2(w_tail.addx));
  assign w_new_y = sat(sx2(w_tail.xy) + sx2(w_tail.xy) + sx2(w_tail.addy));
`else
  assign w_new_x = w_tail.x2 - w_tail.y2 + w_tail.addx;
  assign w_new_y = {w_tail.xy[W-2:0], 1'b0} + w_tail.addy;
`endif

  // Result selection by draw mode, escape state and iteration cutoff.
  always_comb begin
    w_res_pxv  = w_tail.pxv;
    w_res_x    = w_tail.x;
    w_res_y    = w_tail.y;
    w_res_iter = w_tail.iter;
    case (w_tail.mode)
      DRAW_CLEAR: begin
        w_res_pxv  = {w_tail.pxv[PXW-1], {(PXW-1){1'b0}}};
        w_res_x    = '0;
        w_res_y    = '0;
        w_res_iter = '0;
      end
      DRAW_MANDELBROT, DRAW_JULIA: begin
        if (!w_esc_in) begin
          if (w_gt4) begin
            w_res_x   = '1;
            w_res_y   = '1;
            w_res_pxv = (w_tail.mode == DRAW_MANDELBROT) ? '0
                        : {w_tail.pxv[PXW-1], w_tail.iter[PXW-2:0]};
          end else begin
            w_res_pxv  = (w_tail.mode == DRAW_MANDELBROT) ? {1'b1, {(PXW-1){1'b0}}}
                         : {w_tail.pxv[PXW-1], {(PXW-1){1'b1}}};
            w_res_iter = w_iter_inc;
            if (w_iter_inc == ITW'(MAX_ITER)) begin
              w_res_x = '1;
              w_res_y = '1;
            end else begin
              w_res_x = w_new_x;
              w_res_y = w_new_y;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Output stage: registered word and its valid flag.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_v_last  <= 1'b0;
      o_Px_Data <= '0;
    end else if (w_adv) begin
      r_v_last  <= r_valid[STAGES-1];
      o_Px_Data <= {w_res_pxv, w_res_x, w_res_y, w_res_iter};
    end
  end

endmodule

// File: tb/tb_fractal_iter_pipe.sv
// Directed bench for fractal_iter_pipe, built with a small 8x4 frame.
module tb_fractal_iter_pipe;
  localparam int W = 32, PXW = 8, ITW = 32, STAGES = 3, HR = 8, VR = 4;
  localparam int DW = PXW + 2*W + ITW;
  localparam logic [1:0] D_CLEAR = 2'd0, D_MANDEL = 2'd1, D_JULIA = 2'd2, D_PASS = 2'd3;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  logic          i_Clk = 1'b0;
  logic          i_Reset;
  logic [DW-1:0] i_Px_Data;
  logic          i_Read_Fifo_Empty, i_Write_Fifo_Full;
  logic [1:0]    i_Draw;
  logic [W-1:0]  i_X_Start, i_Y_Start, i_X_Inc, i_Y_Inc, i_Cx, i_Cy;
  logic [DW-1:0] o_Px_Data;
  logic          o_Read_Fifo_Ack, o_Write_Fifo_Wrreq, o_Frame_Done;

  int checks = 0;
  int errors = 0;

  always #5 i_Clk = ~i_Clk;

  fractal_iter_pipe #(.W(W), .FRAC(27), .ITW(ITW), .PXW(PXW), .STAGES(STAGES),
                      .H_RES(HR), .V_RES(VR), .MAX_ITER(127)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Px_Data(i_Px_Data),
    .i_Read_Fifo_Empty(i_Read_Fifo_Empty), .i_Write_Fifo_Full(i_Write_Fifo_Full),
    .i_Draw(i_Draw), .i_X_Start(i_X_Start), .i_Y_Start(i_Y_Start),
    .i_X_Inc(i_X_Inc), .i_Y_Inc(i_Y_Inc), .i_Cx(i_Cx), .i_Cy(i_Cy),
    .o_Px_Data(o_Px_Data), .o_Read_Fifo_Ack(o_Read_Fifo_Ack),
    .o_Write_Fifo_Wrreq(o_Write_Fifo_Wrreq), .o_Frame_Done(o_Frame_Done)
  );

  function automatic logic [DW-1:0] mk(input logic [PXW-1:0] pv, input logic [W-1:0] x,
                                       input logic [W-1:0] y, input logic [ITW-1:0] it);
    return {pv, x, y, it};
  endfunction

  task automatic set_view(input logic [W-1:0] xs, input logic [W-1:0] ys, input logic [W-1:0] xi,
                          input logic [W-1:0] yi, input logic [W-1:0] cx, input logic [W-1:0] cy);
    i_X_Start = xs; i_Y_Start = ys; i_X_Inc = xi; i_Y_Inc = yi; i_Cx = cx; i_Cy = cy;
  endtask

  task automatic do_reset();
    @(negedge i_Clk);
    i_Reset = 1'b1; i_Read_Fifo_Empty = 1'b1; i_Write_Fifo_Full = 1'b0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b0;
  endtask

  // Offers one word; returns the pushed word and cycles from ack to wrreq (-1 if none).
  task automatic send_word(input logic [DW-1:0] w, output logic [DW-1:0] got, output int lat);
    got = '0;
    lat = -1;
    @(negedge i_Clk);
    i_Px_Data = w; i_Read_Fifo_Empty = 1'b0;
    #1;
    if (!o_Read_Fifo_Ack) begin
      i_Read_Fifo_Empty = 1'b1;
      return;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_Clk);
      i_Read_Fifo_Empty = 1'b1;
      #1;
      if (o_Write_Fifo_Wrreq) begin
        got = o_Px_Data;
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_Draw = D_MANDEL;
    set_view(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge i_Clk);
    i_Reset = 1'b1; i_Read_Fifo_Empty = 1'b0; i_Write_Fifo_Full = 1'b0;
    @(negedge i_Clk);
    #1;
    checks++; if (o_Px_Data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", o_Px_Data); end
    checks++; if (o_Write_Fifo_Wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq got %b want 0", o_Write_Fifo_Wrreq); end
    checks++; if (o_Frame_Done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", o_Frame_Done); end
    checks++; if (o_Read_Fifo_Ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", o_Read_Fifo_Ack); end
    @(negedge i_Clk);
    i_Reset = 1'b0;
    #1;
    checks++; if (o_Read_Fifo_Ack !== 1'b1) begin errors++; $display("FAIL post_reset_ack got %b want 1", o_Read_Fifo_Ack); end
    i_Read_Fifo_Empty = 1'b1;
  endtask

  task automatic test_clear();
    logic [DW-1:0] got; int lat;
    i_Draw = D_CLEAR;
    do_reset();
    send_word(mk(8'hA5, ONES, ONES, 32'd5), got, lat);
    checks++; if (lat !== STAGES) begin errors++; $display("FAIL clear_latency got %0d want %0d", lat, STAGES); end
    checks++; if (got !== mk(8'h80, 32'h0, 32'h0, 32'h0)) begin errors++; $display("FAIL clear_word got %h want %h", got, mk(8'h80, 32'h0, 32'h0, 32'h0)); end
  endtask

  task automatic test_mandel();
    logic [DW-1:0] got, exp; int lat;
    i_Draw = D_MANDEL;
    // mag exactly 4.0: no escape
    set_view(32'h0010_0000, 32'h0000_0300, 32'h11, 32'h22, 32'h0, 32'h0);
    do_reset();
    send_word(mk(8'h00, 32'h1000_0000, 32'h0000_0001, 32'd3), got, lat);
    exp = mk(8'h80, 32'h2010_0000, 32'h0000_0304, 32'd4);
    checks++; if (lat !== STAGES) begin errors++; $display("FAIL mandel_latency got %0d want %0d", lat, STAGES); end
    checks++; if (got !== exp) begin errors++; $display("FAIL mandel_mag4 got %h want %h", got, exp); end
    // zero X/Y seeded from viewport
    set_view(32'h0800_0000, 32'h0400_0000, 32'h11, 32'h22, 32'h0, 32'h0);
    do_reset();
    send_word(mk(8'h00, 32'h0, 32'h0, 32'd0), got, lat);
    exp = mk(8'h80, 32'h0E00_0000, 32'h0C00_0000, 32'd1);
    checks++; if (got !== exp) begin errors++; $display("FAIL mandel_seed got %h want %h", got, exp); end
    // escape
    send_word(mk(8'h7E, 32'h1000_0000, 32'h0800_0000, 32'd9), got, lat);
    exp = mk(8'h00, ONES, ONES, 32'd9);
    checks++; if (got !== exp) begin errors++; $display("FAIL mandel_escape got %h want %h", got, exp); end
    // already escaped passes unchanged
    send_word(mk(8'h3C, ONES, ONES, 32'd77), got, lat);
    exp = mk(8'h3C, ONES, ONES, 32'd77);
    checks++; if (got !== exp) begin errors++; $display("FAIL mandel_escaped_in got %h want %h", got, exp); end
  endtask

  task automatic test_julia();
    logic [DW-1:0] got, exp; int lat;
    i_Draw = D_JULIA;
    set_view(32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0010, 32'h0000_0020);
    do_reset();
    send_word(mk(8'hC3, 32'h1000_0000, 32'h0800_0000, 32'd9), got, lat);
    exp = mk(8'h89, ONES, ONES, 32'd9);
    checks++; if (got !== exp) begin errors++; $display("FAIL julia_escape got %h want %h", got, exp); end
    send_word(mk(8'h05, 32'hF800_0000, 32'h0800_0000, 32'd2), got, lat);
    exp = mk(8'h7F, 32'h0000_0010, 32'hF000_0020, 32'd3);
    checks++; if (got !== exp) begin errors++; $display("FAIL julia_iterate got %h want %h", got, exp); end
  endtask

  task automatic test_max_iter();
    logic [DW-1:0] got, exp; int lat;
    i_Draw = D_JULIA;
    set_view(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    do_reset();
    send_word(mk(8'h12, 32'h0400_0000, 32'h0000_0001, 32'd126), got, lat);
    exp = mk(8'h7F, ONES, ONES, 32'd127);
    checks++; if (got !== exp) begin errors++; $display("FAIL max_iter got %h want %h", got, exp); end
  endtask

  task automatic test_pass();
    logic [DW-1:0] got, exp; int lat;
    i_Draw = D_PASS;
    do_reset();
    exp = mk(8'h5A, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D);
    send_word(exp, got, lat);
    checks++; if (got !== exp) begin errors++; $display("FAIL pass_mode got %h want %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got[$];
    int sent;
    i_Draw = D_PASS;
    do_reset();
    sent = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge i_Clk);
      i_Write_Fifo_Full = (cyc >= 4 && cyc < 11);
      i_Read_Fifo_Empty = (sent >= 10);
      i_Px_Data = mk(8'(sent), 32'(sent * 3), 32'(sent * 5 + 1), 32'(sent));
      #1;
      if (cyc >= 4 && cyc < 11) begin
        checks++;
        if (o_Read_Fifo_Ack !== 1'b0 || o_Write_Fifo_Wrreq !== 1'b0) begin
          errors++; $display("FAIL stall_hold cyc %0d ack %b wrreq %b want 0 0", cyc, o_Read_Fifo_Ack, o_Write_Fifo_Wrreq);
        end
      end
      if (o_Write_Fifo_Wrreq) got.push_back(o_Px_Data);
      if (o_Read_Fifo_Ack) sent++;
    end
    i_Read_Fifo_Empty = 1'b1; i_Write_Fifo_Full = 1'b0;
    checks++; if (got.size() != 10) begin errors++; $display("FAIL stream_count got %0d want 10", got.size()); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      checks++;
      if (got[i] !== mk(8'(i), 32'(i * 3), 32'(i * 5 + 1), 32'(i))) begin
        errors++; $display("FAIL stream_order idx %0d got %h want %h", i, got[i], mk(8'(i), 32'(i * 3), 32'(i * 5 + 1), 32'(i)));
      end
    end
  endtask

  task automatic test_frame();
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp;
    int sent, pulses, fd_at;
    i_Draw = D_MANDEL;
    set_view(32'h0000_0100, 32'h0, 32'h10, 32'h100, 32'h0, 32'h0);
    do_reset();
    sent = 0; pulses = 0; fd_at = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge i_Clk);
      if (sent == 10) i_X_Start = 32'h0000_0200;
      i_Read_Fifo_Empty = (sent >= HR * VR + 8);
      i_Px_Data = mk(8'h00, 32'h0, 32'h0, 32'h0);
      #1;
      if (o_Frame_Done) begin pulses++; fd_at = sent; end
      if (o_Write_Fifo_Wrreq) got.push_back(o_Px_Data);
      if (o_Read_Fifo_Ack) sent++;
    end
    i_Read_Fifo_Empty = 1'b1;
    checks++; if (pulses != 1) begin errors++; $display("FAIL frame_pulses got %0d want 1", pulses); end
    checks++; if (fd_at != HR * VR) begin errors++; $display("FAIL frame_done_pos got %0d want %0d", fd_at, HR * VR); end
    checks++; if (got.size() != HR * VR + 8) begin errors++; $display("FAIL frame_count got %0d want %0d", got.size(), HR * VR + 8); end
    for (int k = 0; k < got.size() && k < HR * VR + 8; k++) begin
      exp = mk(8'h80, ((k < HR * VR) ? 32'h100 : 32'h200) + 32'((k % HR) * 16),
               32'(((k / HR) % VR) * 256), 32'd1);
      checks++;
      if (got[k] !== exp) begin errors++; $display("FAIL frame_word idx %0d got %h want %h", k, got[k], exp); end
    end
    // mid-stream reset
    @(negedge i_Clk);
    i_Read_Fifo_Empty = 1'b0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    @(negedge i_Clk);
    #1;
    checks++; if (o_Write_Fifo_Wrreq !== 1'b1) begin errors++; $display("FAIL restream_wrreq got %b want 1", o_Write_Fifo_Wrreq); end
    i_Reset = 1'b1;
    @(negedge i_Clk);
    #1;
    checks++; if (o_Px_Data !== '0) begin errors++; $display("FAIL midreset_data got %h want 0", o_Px_Data); end
    checks++; if (o_Write_Fifo_Wrreq !== 1'b0) begin errors++; $display("FAIL midreset_wrreq got %b want 0", o_Write_Fifo_Wrreq); end
    i_Reset = 1'b0; i_Read_Fifo_Empty = 1'b1;
  endtask

  initial begin
    i_Reset = 1'b1; i_Read_Fifo_Empty = 1'b1; i_Write_Fifo_Full = 1'b0;
    i_Draw = D_MANDEL; i_Px_Data = '0;
    set_view(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_clear();
    test_mandel();
    test_julia();
    test_max_iter();
    test_pass();
    test_back_to_back();
    test_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
